// File: rtl/sha3_job_arbiter.sv
// Round-robin arbiter that shares one sha3 core between two requesters and
// streams each granted job's message blocks into the core, one block at a time.
module sha3_job_arbiter #(
    parameter int unsigned DATA_W  = 1152,
    parameter int unsigned OUT_W   = 512,
    parameter int unsigned CTRL_W  = 10,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_start,
    input  logic [2*CTRL_W-1:0]   req_ctrl,
    output logic [1:0]            req_grant,
    input  logic [1:0]            req_blk_valid,
    input  logic [2*DATA_W-1:0]   req_blk_data,
    output logic [1:0]            req_blk_ready,
    output logic [1:0]            req_done,
    output logic [1:0]            req_err,
    output logic [OUT_W-1:0]      digest,
    output logic                  core_start,
    output logic [CTRL_W-1:0]     core_ctrl,
    output logic [DATA_W-1:0]     core_in,
    input  logic                  core_blk_ack,
    input  logic                  core_done,
    input  logic [OUT_W-1:0]      core_out
);

    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StFetch,
        StStart,
        StWaitAck,
        StWaitDone,
        StFinish
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                first_q, first_d;
    logic [6:0]          remaining_q, remaining_d;
    logic [15:0]         tmo_q, tmo_d;
    logic [1:0]          err_q, err_d;
    logic [CTRL_W-1:0]   core_ctrl_q, core_ctrl_d;
    logic [DATA_W-1:0]   core_in_q, core_in_d;
    logic [OUT_W-1:0]    digest_q, digest_d;

    logic [CTRL_W-1:0]   ctrl_sel;
    logic [DATA_W-1:0]   data_sel;
    logic                valid_sel;
    logic [1:0]          owner_oh;
    logic                tmo_hit;

    assign ctrl_sel  = owner_q ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];
    assign data_sel  = owner_q ? req_blk_data[2*DATA_W-1:DATA_W] : req_blk_data[DATA_W-1:0];
    assign valid_sel = owner_q ? req_blk_valid[1] : req_blk_valid[0];
    assign owner_oh  = owner_q ? 2'b10 : 2'b01;
    assign tmo_hit   = (tmo_q == TmoLast);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        first_d      = first_q;
        remaining_d  = remaining_q;
        err_d        = 2'b00;
        core_ctrl_d  = core_ctrl_q;
        core_in_d    = core_in_q;
        digest_d     = digest_q;

        unique case (state_q)
            StIdle: begin
                if (req_start != 2'b00) begin
                    // On a tie the requester that was not served last wins.
                    owner_d = (req_start == 2'b11) ? ~last_grant_q : req_start[1];
                    state_d = StGrant;
                end
            end
            StGrant: begin
                core_ctrl_d  = ctrl_sel;
                remaining_d  = ctrl_sel[9:3];
                first_d      = 1'b1;
                last_grant_d = owner_q;
                state_d      = StFetch;
            end
            StFetch: begin
                if (valid_sel) begin
                    core_in_d = data_sel;
                    state_d   = first_q ? StStart : StWaitAck;
                end
            end
            StStart: begin
                first_d = 1'b0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (core_done && (remaining_q != 7'd0)) begin
                    err_d[owner_q] = 1'b1;
                    state_d        = StIdle;
                end else if (core_done) begin
                    // Digest valid on the last block: completion needs no separate ack.
                    digest_d = core_out;
                    state_d  = StFinish;
                end else if (core_blk_ack && (remaining_q == 7'd0)) begin
                    state_d = StWaitDone;
                end else if (core_blk_ack) begin
                    remaining_d = remaining_q - 7'd1;
                    state_d     = StFetch;
                end else if (tmo_hit) begin
                    err_d[owner_q] = 1'b1;
                    state_d        = StIdle;
                end
            end
            StWaitDone: begin
                if (core_done) begin
                    digest_d = core_out;
                    state_d  = StFinish;
                end else if (tmo_hit) begin
                    err_d[owner_q] = 1'b1;
                    state_d        = StIdle;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Watchdog restarts on every state change and only runs while waiting on the core.
    always_comb begin
        tmo_d = tmo_q;
        if (state_d != state_q) begin
            tmo_d = 16'd0;
        end else if ((state_q == StWaitAck) || (state_q == StWaitDone)) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    always_comb begin
        req_grant     = 2'b00;
        req_blk_ready = 2'b00;
        req_done      = 2'b00;
        core_start    = 1'b0;
        unique case (state_q)
            StGrant:  req_grant     = owner_oh;
            StFetch:  req_blk_ready = owner_oh;
            StStart:  core_start    = 1'b1;
            StFinish: req_done      = owner_oh;
            default:  ;
        endcase
    end

    assign req_err   = err_q;
    assign core_ctrl = core_ctrl_q;
    assign core_in   = core_in_q;
    assign digest    = digest_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            first_q      <= 1'b0;
            remaining_q  <= 7'd0;
            tmo_q        <= 16'd0;
            err_q        <= 2'b00;
            core_ctrl_q  <= '0;
            core_in_q    <= '0;
            digest_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            first_q      <= first_d;
            remaining_q  <= remaining_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            core_ctrl_q  <= core_ctrl_d;
            core_in_q    <= core_in_d;
            digest_q     <= digest_d;
        end
    end

endmodule
